// File: rtl/duck_motion.sv
// -----------------------------------------------------------------------------
// duck_motion
//   Per-frame motion controller for the player duck sprite. Converts the raw
//   jump/duck buttons into the sprite's vertical position, a pose index and a
//   run-animation frame select. All state advances once per accepted video
//   frame (frame strobe with pause low); outputs are registered and therefore
//   change one clk after the strobe and stay stable for the whole active frame.
//
//   Optional feature macro: DUCK_FAST_FALL_EN
//     When defined, holding duck while airborne quadruples the fall-rate
//     decrement and, on touchdown, lands straight into DUCK instead of RUN.
//     When undefined, duck is ignored while airborne.
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   synchronous reset, active low
//   frame      in   one-cycle strobe at the start of vertical blank
//   btn_jump   in   raw jump button (asynchronous)
//   btn_duck   in   raw duck button (asynchronous)
//   pause      in   level; frame strobes are ignored while high
//   spry       out  signed sprite top-edge y position (CORDW bits)
//   pose       out  0=RUN, 1=JUMP, 2=DUCK
//   anim_frame out  run-cycle bitmap select
//   airborne   out  high while in JUMP
//   land       out  one-clk pulse on touchdown
// -----------------------------------------------------------------------------
module duck_motion #(
  parameter int CORDW    = 10,
  parameter int GROUND_Y = 240,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int ANIM_DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    btn_jump,
  input  logic                    btn_duck,
  input  logic                    pause,
  output logic signed [CORDW-1:0] spry,
  output logic [1:0]              pose,
  output logic                    anim_frame,
  output logic                    airborne,
  output logic                    land
);

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // State encoding doubles as the pose index.
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_JUMP = 2'd1;
  localparam logic [1:0] ST_DUCK = 2'd2;

  // Physics constants in the widened (CORDW+1) signed domain.
  localparam logic signed [CORDW:0] GROUND_W  = (CORDW+1)'(GROUND_Y);
  localparam logic signed [CORDW:0] V0_W      = (CORDW+1)'(JUMP_V0);
  localparam logic signed [CORDW:0] GRAV_W    = (CORDW+1)'(GRAVITY);
  localparam logic signed [CORDW:0] TAKEOFF_W = GROUND_W - V0_W;
  localparam logic signed [CORDW:0] VEL0_W    = V0_W - GRAV_W;
`ifdef DUCK_FAST_FALL_EN
  localparam logic signed [CORDW:0] FAST_W    = (CORDW+1)'(4 * GRAVITY);
`endif
  localparam logic [AW-1:0]         ANIM_MAX  = AW'(ANIM_DIV - 1);

  // Button synchronizers and frame-rate previous jump sample
  logic jump_meta_q, jump_sync_q, duck_meta_q, duck_sync_q;
  logic jump_prev_q, jump_prev_d;

  // Motion state
  logic [1:0]              state_q, state_d;
  logic signed [CORDW-1:0] spry_q, spry_d;
  logic signed [CORDW:0]   vel_q, vel_d;
  logic [AW-1:0]           anim_cnt_q, anim_cnt_d;
  logic                    anim_q, anim_d;
  logic                    airborne_q, airborne_d;
  logic                    land_q, land_d;

  // Helper signals
  logic                    frame_ok_s;
  logic                    jump_edge_s;
  logic signed [CORDW:0]   ny_s;
  logic signed [CORDW:0]   dec_s;
  logic [1:0]              land_state_s;

  assign frame_ok_s  = frame & ~pause;
  assign jump_edge_s = jump_sync_q & ~jump_prev_q;
  // Candidate next height, one bit wider so the landing test cannot wrap.
  assign ny_s        = {spry_q[CORDW-1], spry_q} - vel_q;

  // Two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jump_meta_q <= 1'b0;
      jump_sync_q <= 1'b0;
      duck_meta_q <= 1'b0;
      duck_sync_q <= 1'b0;
    end else begin
      jump_meta_q <= btn_jump;
      jump_sync_q <= jump_meta_q;
      duck_meta_q <= btn_duck;
      duck_sync_q <= duck_meta_q;
    end
  end

  // Airborne duck handling: fall rate and landing destination
  always_comb begin
    dec_s        = GRAV_W;
    land_state_s = ST_RUN;
`ifdef DUCK_FAST_FALL_EN
    if (duck_sync_q) begin
      dec_s        = FAST_W;
      land_state_s = ST_DUCK;
    end else begin
      dec_s        = GRAV_W;
      land_state_s = ST_RUN;
    end
`endif
  end

  // Next-state logic; everything holds unless an accepted frame arrives
  always_comb begin
    state_d     = state_q;
    spry_d      = spry_q;
    vel_d       = vel_q;
    anim_cnt_d  = anim_cnt_q;
    anim_d      = anim_q;
    jump_prev_d = jump_prev_q;
    land_d      = 1'b0;
    if (frame_ok_s) begin
      // The previous sample advances in every state so a jump held through
      // DUCK or JUMP never fires as a fresh edge afterwards.
      jump_prev_d = jump_sync_q;
      case (state_q)
        ST_RUN: begin
          if (duck_sync_q) begin
            state_d = ST_DUCK;
          end else if (jump_edge_s) begin
            state_d = ST_JUMP;
            spry_d  = TAKEOFF_W[CORDW-1:0];
            vel_d   = VEL0_W;
          end else if (anim_cnt_q == ANIM_MAX) begin
            anim_cnt_d = {AW{1'b0}};
            anim_d     = ~anim_q;
          end else begin
            anim_cnt_d = anim_cnt_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_DUCK: begin
          if (!duck_sync_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DUCK;
          end
        end
        ST_JUMP: begin
          if (ny_s >= GROUND_W) begin
            state_d = land_state_s;
            spry_d  = GROUND_W[CORDW-1:0];
            vel_d   = {(CORDW+1){1'b0}};
            land_d  = 1'b1;
          end else begin
            spry_d  = ny_s[CORDW-1:0];
            vel_d   = vel_q - dec_s;
          end
        end
        default: begin
          state_d = ST_RUN;
          spry_d  = GROUND_W[CORDW-1:0];
          vel_d   = {(CORDW+1){1'b0}};
        end
      endcase
    end else begin
      land_d = 1'b0;
    end
    airborne_d = (state_d == ST_JUMP);
  end

  // Motion state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      spry_q      <= GROUND_W[CORDW-1:0];
      vel_q       <= {(CORDW+1){1'b0}};
      anim_cnt_q  <= {AW{1'b0}};
      anim_q      <= 1'b0;
      airborne_q  <= 1'b0;
      land_q      <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      spry_q      <= spry_d;
      vel_q       <= vel_d;
      anim_cnt_q  <= anim_cnt_d;
      anim_q      <= anim_d;
      airborne_q  <= airborne_d;
      land_q      <= land_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  assign spry       = spry_q;
  assign pose       = state_q;
  assign anim_frame = anim_q;
  assign airborne   = airborne_q;
  assign land       = land_q;

endmodule

// File: tb/tb_duck_motion.sv
// -----------------------------------------------------------------------------
// tb_duck_motion
//   Self-checking bench for duck_motion (default build). The reference model
//   describes the duck in terms of "frames since take-off" and "RUN frames
//   seen": the jump height is the closed-form ballistic sum, and the run
//   animation bit is the parity of completed ANIM_DIV-frame groups.
// -----------------------------------------------------------------------------
module tb_duck_motion;

  localparam int CORDW    = 10;
  localparam int GROUND   = 240;
  localparam int V0       = 12;
  localparam int G        = 1;
  localparam int ANIM_DIV = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    frame;
  logic                    btn_jump;
  logic                    btn_duck;
  logic                    pause;
  logic signed [CORDW-1:0] spry;
  logic [1:0]              pose;
  logic                    anim_frame;
  logic                    airborne;
  logic                    land;

  int n_cmp;
  int n_bad;

  // Reference model: pose index, frames since take-off, RUN frames, prev jump
  int m_pose;
  int m_n;
  int m_run;
  bit m_prev;
  bit m_land;
  int m_y;

  duck_motion #(
    .CORDW(CORDW), .GROUND_Y(GROUND), .JUMP_V0(V0), .GRAVITY(G), .ANIM_DIV(ANIM_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .btn_jump(btn_jump),
    .btn_duck(btn_duck), .pause(pause), .spry(spry), .pose(pose),
    .anim_frame(anim_frame), .airborne(airborne), .land(land)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Height above ground after n frames of flight (take-off frame is n=1).
  function automatic int height(input int n);
    return V0 * n - (G * n * (n - 1)) / 2;
  endfunction

  task automatic model_reset();
    m_pose = 0; m_n = 0; m_run = 0; m_prev = 1'b0; m_land = 1'b0; m_y = GROUND;
  endtask

  task automatic model_step(input bit j, input bit d, input bit p);
    bit edge_j;
    m_land = 1'b0;
    if (!p) begin
      edge_j = j && !m_prev;
      m_prev = j;
      case (m_pose)
        0: begin
          if (d) m_pose = 2;
          else if (edge_j) begin m_pose = 1; m_n = 1; end
          else m_run++;
        end
        2: if (!d) m_pose = 0;
        1: begin
          m_n++;
          if (height(m_n) <= 0) begin m_pose = 0; m_n = 0; m_land = 1'b1; end
        end
        default: m_pose = 0;
      endcase
    end
    m_y = (m_pose == 1) ? GROUND - height(m_n) : GROUND;
  endtask

  function automatic bit exp_anim();
    return bit'((m_run / ANIM_DIV) % 2);
  endfunction

  // Drive one frame slot; on return the DUT outputs for this frame are valid.
  task automatic do_frame(input bit j, input bit d, input bit p);
    btn_jump = j; btn_duck = d; pause = p;
    repeat (3) @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    model_step(j, d, p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame = 1'b0; btn_jump = 1'b0; btn_duck = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++; if (spry !== 10'sd240) begin n_bad++; $display("FAIL reset_spry got %0d exp 240", spry); end
    n_cmp++; if (pose !== 2'd0) begin n_bad++; $display("FAIL reset_pose got %0d exp 0", pose); end
    n_cmp++; if (anim_frame !== 1'b0) begin n_bad++; $display("FAIL reset_anim got %0b exp 0", anim_frame); end
    n_cmp++; if (airborne !== 1'b0 || land !== 1'b0) begin n_bad++; $display("FAIL reset_flags got %0b%0b exp 00", airborne, land); end
  endtask

  task automatic test_run_anim();
    for (int i = 1; i <= 20; i++) begin
      do_frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (anim_frame !== exp_anim()) begin n_bad++; $display("FAIL run_anim f%0d got %0b exp %0b", i, anim_frame, exp_anim()); end
      n_cmp++; if (spry !== 10'sd240 || pose !== 2'd0) begin n_bad++; $display("FAIL run_pos f%0d got %0d/%0d exp 240/0", i, spry, pose); end
      if (i == 8 || i == 16) begin
        n_cmp++; if (anim_frame !== (i == 8)) begin n_bad++; $display("FAIL run_toggle f%0d got %0b exp %0b", i, anim_frame, (i == 8)); end
      end
    end
  endtask

  task automatic test_jump();
    do_frame(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 27; i++) begin
      do_frame(i <= 3, 1'b0, 1'b0);
      n_cmp++; if (spry !== m_y || pose !== m_pose[1:0] || airborne !== (m_pose == 1) || land !== m_land) begin
        n_bad++; $display("FAIL jump f%0d got y=%0d p=%0d a=%0b l=%0b exp y=%0d p=%0d l=%0b", i, spry, pose, airborne, land, m_y, m_pose, m_land);
      end
      if (i == 1) begin n_cmp++; if (spry !== 10'sd228) begin n_bad++; $display("FAIL takeoff got %0d exp 228", spry); end end
      if (i == 12 || i == 13) begin n_cmp++; if (spry !== 10'sd162) begin n_bad++; $display("FAIL apex f%0d got %0d exp 162", i, spry); end end
      if (i == 25) begin
        n_cmp++; if (spry !== 10'sd240 || land !== 1'b1 || pose !== 2'd0) begin n_bad++; $display("FAIL touchdown got y=%0d l=%0b p=%0d exp 240/1/0", spry, land, pose); end
        @(negedge clk);
        n_cmp++; if (land !== 1'b0) begin n_bad++; $display("FAIL land_width got %0b exp 0", land); end
      end
    end
  endtask

  task automatic test_hold_jump();
    do_frame(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      do_frame(1'b1, 1'b0, 1'b0);
      n_cmp++; if (spry !== m_y || pose !== m_pose[1:0]) begin n_bad++; $display("FAIL hold f%0d got %0d/%0d exp %0d/%0d", i, spry, pose, m_y, m_pose); end
    end
    n_cmp++; if (pose !== 2'd0 || spry !== 10'sd240) begin n_bad++; $display("FAIL no_retrigger got %0d/%0d exp 0/240", pose, spry); end
    do_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_duck_jump();
    do_frame(1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0);
    n_cmp++; if (pose !== 2'd2 || spry !== 10'sd240 || airborne !== 1'b0) begin n_bad++; $display("FAIL duck_prio got p=%0d y=%0d a=%0b exp 2/240/0", pose, spry, airborne); end
    do_frame(1'b1, 1'b1, 1'b0);
    n_cmp++; if (pose !== 2'd2) begin n_bad++; $display("FAIL duck_hold got %0d exp 2", pose); end
    do_frame(1'b1, 1'b0, 1'b0);
    n_cmp++; if (pose !== 2'd0 || spry !== 10'sd240) begin n_bad++; $display("FAIL duck_release got %0d/%0d exp 0/240", pose, spry); end
    do_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midjump();
    do_frame(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 6; i++) do_frame(1'b0, 1'b0, 1'b0);
    n_cmp++; if (spry !== 10'sd183) begin n_bad++; $display("FAIL midjump_y got %0d exp 183", spry); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_cmp++; if (spry !== 10'sd240 || pose !== 2'd0 || airborne !== 1'b0 || land !== 1'b0) begin
      n_bad++; $display("FAIL midjump_reset got y=%0d p=%0d a=%0b l=%0b exp 240/0/0/0", spry, pose, airborne, land);
    end
  endtask

  task automatic test_pause();
    do_frame(1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_frame(1'b0, 1'b0, 1'b1);
      n_cmp++; if (spry !== m_y || pose !== 2'd1) begin n_bad++; $display("FAIL pause_air got %0d/%0d exp %0d/1", spry, pose, m_y); end
    end
    for (int i = 0; i < 22; i++) begin
      do_frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (spry !== m_y || land !== m_land || pose !== m_pose[1:0]) begin n_bad++; $display("FAIL pause_resume got %0d/%0b exp %0d/%0b", spry, land, m_y, m_land); end
    end
    for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_frame(1'b0, 1'b0, 1'b1);
      n_cmp++; if (anim_frame !== exp_anim()) begin n_bad++; $display("FAIL pause_anim got %0b exp %0b", anim_frame, exp_anim()); end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    bit j, d, p;
    j = 1'b0; d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) j = ~j;
      if ($urandom_range(0, 5) == 0) d = ~d;
      p = ($urandom_range(0, 9) == 0);
      do_frame(j, d, p);
      n_cmp++; if (spry !== m_y || pose !== m_pose[1:0] || anim_frame !== exp_anim() || airborne !== (m_pose == 1) || land !== m_land) begin
        n_bad++; $display("FAIL random f%0d got y=%0d p=%0d an=%0b a=%0b l=%0b exp y=%0d p=%0d an=%0b l=%0b",
                          i, spry, pose, anim_frame, airborne, land, m_y, m_pose, exp_anim(), m_land);
      end
      if (m_land) begin
        @(negedge clk);
        n_cmp++; if (land !== 1'b0) begin n_bad++; $display("FAIL random_land_width got %0b exp 0", land); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_run_anim();
    test_jump();
    test_hold_jump();
    test_duck_jump();
    test_reset_midjump();
    test_pause();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
